// File: rtl/mcx_pkg.sv
// Shared types and constants for the mcx_seq micro-sequencer.
// Optional single-step mode is selected with the MCX_SEQ_STEP_EN macro (see mcx_seq.sv).
package mcx_pkg;

  localparam int unsigned COND_W = 2;
  localparam int unsigned INST_W = 4;
  localparam int unsigned HDR_W  = COND_W + INST_W;

  localparam logic [INST_W-1:0] OP_JMP  = 4'h3;
  localparam logic [INST_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [COND_W-1:0] {
    COND_ALWAYS = 2'd0,
    COND_ZERO   = 2'd1,
    COND_NZERO  = 2'd2,
    COND_NEG    = 2'd3
  } cond_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/mcx_cond.sv
// Condition evaluator: decides whether the decoded instruction takes effect.
module mcx_cond
  import mcx_pkg::*;
(
  input  cond_e cond,
  input  logic  acc_zero,
  input  logic  acc_neg,
  output logic  take
);

  always_comb begin
    take = 1'b1;
    case (cond)
      COND_ALWAYS: take = 1'b1;
      COND_ZERO:   take = acc_zero;
      COND_NZERO:  take = !acc_zero;
      COND_NEG:    take = acc_neg;
    endcase
  end

endmodule

// File: rtl/mcx_seq.sv
// Fetch/decode/issue micro-sequencer with conditional jumps and halt.
// Define MCX_SEQ_STEP_EN to add the step input and single-step pacing after each issue.
module mcx_seq
  import mcx_pkg::*;
#(
  parameter int unsigned PROG_LEN = 7,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ARG_W    = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       halt_req,
`ifdef MCX_SEQ_STEP_EN
  input  logic                       step,
`endif
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [HDR_W+3*ARG_W-1:0]   mem_rdata,
  input  logic                       mem_valid,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [INST_W-1:0]          issue_inst,
  output logic [3*ARG_W-1:0]         issue_args,
  input  logic                       acc_zero,
  input  logic                       acc_neg,
  output logic [ADDR_W-1:0]          pc,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned ARGS_W = 3 * ARG_W;
  localparam int unsigned WORD_W = HDR_W + ARGS_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                mem_req_q, mem_req_d;
  logic                issue_valid_q, issue_valid_d;
  logic [INST_W-1:0]   issue_inst_q, issue_inst_d;
  logic [ARGS_W-1:0]   issue_args_q, issue_args_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  cond_e               dec_cond;
  logic [INST_W-1:0]   dec_inst;
  logic [ARGS_W-1:0]   dec_args;
  logic [ARG_W-1:0]    dec_arg0;
  logic                take;
  logic                boundary;
  logic [ADDR_W-1:0]   next_pc;

  assign dec_cond = cond_e'(word_q[WORD_W-1 -: COND_W]);
  assign dec_inst = word_q[ARGS_W +: INST_W];
  assign dec_args = word_q[ARGS_W-1:0];
  assign dec_arg0 = word_q[ARGS_W-1 -: ARG_W];

  mcx_cond u_cond (
    .cond     (dec_cond),
    .acc_zero (acc_zero),
    .acc_neg  (acc_neg),
    .take     (take)
  );

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(PROG_LEN - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    word_d       = word_q;
    issue_inst_d = issue_inst_q;
    issue_args_d = issue_args_q;
    err_d        = err_q;
    boundary     = 1'b0;
    next_pc      = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_req_q && mem_valid) begin
          word_d  = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!take) begin
          boundary = 1'b1;
          next_pc  = pc_inc(pc_q);
        end else if (dec_inst == OP_JMP) begin
          if (dec_arg0 >= ARG_W'(PROG_LEN)) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            boundary = 1'b1;
            next_pc  = dec_arg0[ADDR_W-1:0];
          end
        end else if (dec_inst == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d      = ST_ISSUE;
          issue_inst_d = dec_inst;
          issue_args_d = dec_args;
        end
      end
      ST_ISSUE: begin
`ifdef MCX_SEQ_STEP_EN
        // After acceptance the pc is advanced but we park here until step.
        if (issue_valid_q) begin
          if (issue_ready) pc_d = pc_inc(pc_q);
        end else if (step) begin
          boundary = 1'b1;
          next_pc  = pc_q;
        end
`else
        if (issue_ready) begin
          boundary = 1'b1;
          next_pc  = pc_inc(pc_q);
        end
`endif
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Instruction boundary: halt_req diverts the return to FETCH.
    if (boundary) begin
      pc_d    = next_pc;
      state_d = halt_req ? ST_HALT : ST_FETCH;
    end

    mem_req_d     = (state_d == ST_FETCH);
    issue_valid_d = (state_d == ST_ISSUE) &&
                    ((state_q != ST_ISSUE) || (issue_valid_q && !issue_ready));
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_HALT);
    done_d        = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      word_q        <= '0;
      mem_req_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      issue_args_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      word_q        <= word_d;
      mem_req_q     <= mem_req_d;
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      issue_args_q  <= issue_args_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign issue_valid = issue_valid_q;
  assign issue_inst  = issue_inst_q;
  assign issue_args  = issue_args_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
